// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers EX results and services word-aligned loads/stores
// against an on-chip data memory. Loads take one wait state, which back-pressures EX.
module mem_stage #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_reg_write,
  output logic        misalign_err
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  state_t        r_state;
  logic [31:0]   r_mem [MEM_WORDS];
  logic [31:0]   r_rdata;
  logic [4:0]    r_ld_rd;
  logic          r_ld_rw;

  logic          w_accept;
  logic          w_misaligned;
  logic          w_store;
  logic          w_load;
  logic          w_rd_nz;
  logic [AW-1:0] w_idx;

  assign ex_ready     = (r_state == IDLE);
  assign w_accept     = ex_valid & ex_ready;
  assign w_idx        = ex_alu_result[AW+1:2];
  assign w_rd_nz      = (ex_rd != 5'd0);
  assign w_misaligned = (ex_mem_read | ex_mem_write) & (ex_alu_result[1:0] != 2'b00);
  // A store wins over a simultaneous read request.
  assign w_store      = w_accept & ex_mem_write & ~w_misaligned;
  assign w_load       = w_accept & ex_mem_read & ~ex_mem_write & ~w_misaligned;

  // Data memory: one synchronous write port, one registered read port, contents not reset.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[w_idx] <= ex_store_data;
    end
    if (w_load) begin
      r_rdata <= r_mem[w_idx];
    end
  end

  // Stage FSM with registered write-back record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ld_rd      <= 5'd0;
      r_ld_rw      <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      wb_reg_write <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      misalign_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_misaligned) begin
              wb_valid     <= 1'b1;
              wb_rd        <= ex_rd;
              wb_data      <= 32'd0;
              misalign_err <= 1'b1;
            end else if (ex_mem_write) begin
              wb_valid <= 1'b1;
              wb_rd    <= ex_rd;
              wb_data  <= ex_alu_result;
            end else if (ex_mem_read) begin
              r_ld_rd <= ex_rd;
              r_ld_rw <= ex_reg_write & w_rd_nz;
              r_state <= LOAD_WAIT;
            end else begin
              wb_valid     <= 1'b1;
              wb_rd        <= ex_rd;
              wb_data      <= ex_alu_result;
              wb_reg_write <= ex_reg_write & w_rd_nz;
            end
          end
        end
        LOAD_WAIT: begin
          wb_valid     <= 1'b1;
          wb_rd        <= r_ld_rd;
          wb_data      <= r_rdata;
          wb_reg_write <= r_ld_rw;
          r_state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage directly downstream of `EX_stage`. It registers each EX result and, for loads and stores, accesses a word-addressed on-chip data memory, using the EX `alu_result` as the byte address. It presents a registered write-back record to the WB stage. Loads insert one wait state, which `ex_ready` back-pressures into EX; ALU results and stores pass with single-cycle latency.

## Interface
- `MEM_WORDS`, default 256: data memory depth in 32-bit words; power of two, ≥ 4.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `ex_valid`  in  1  EX presents a valid op this cycle.
- `ex_ready`  out  1  stage can accept; transfer occurs when `ex_valid & ex_ready`.
- `ex_alu_result`  in  32  ALU result; the byte address for loads and stores.
- `ex_store_data`  in  32  store data (EX `rs2_val`).
- `ex_rd`  in  5  destination register index.
- `ex_mem_read`  in  1  op is a load.
- `ex_mem_write`  in  1  op is a store.
- `ex_reg_write`  in  1  op writes `rd`.
- `wb_valid`  out  1  write-back record valid; one-cycle pulse per accepted op.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  32  load data or ALU result.
- `wb_reg_write`  out  1  WB must write `wb_rd`.
- `misalign_err`  out  1  one-cycle pulse, coincident with `wb_valid`, for a misaligned load or store.

## Operation
- **Word index:** `ex_alu_result[log2(MEM_WORDS)+1 : 2]`. Upper address bits are ignored, so addresses wrap modulo `MEM_WORDS*4`.
- **Misaligned:** `ex_alu_result[1:0] != 0` on a load or store.
- **Memory:**
  - Synchronous write, synchronous registered read, one port each.
  - Memory contents are not reset.
- **FSM states:** IDLE and LOAD_WAIT.
- **IDLE:** `ex_ready=1`. On accept, the op is classified as follows.
  - **Store** (`ex_mem_write=1`, aligned): memory word is written at the accept edge. Next cycle: `wb_valid=1`, `wb_reg_write=0`, `wb_data=ex_alu_result`.
  - **Store with `ex_mem_read` also set:** the store takes priority and the load is ignored.
  - **Load** (aligned): the memory read is issued at the accept edge. Latch `rd` and `reg_write`, then go to LOAD_WAIT.
  - **ALU op** (neither read nor write): next cycle `wb_valid=1`, `wb_data=ex_alu_result`, `wb_rd=ex_rd`.
  - **Misaligned load or store:**
    - No memory write occurs.
    - Next cycle: `wb_valid=1`, `wb_reg_write=0`, `wb_data=0`, `misalign_err=1`.
    - There is no wait state.
- **LOAD_WAIT:** `ex_ready=0`.
  - At the next edge, load `wb_data` with the read data and set `wb_valid=1`.
  - `wb_reg_write` = latched `reg_write`, gated by `rd != 0`.
  - Return to IDLE.
- **`wb_reg_write` rules** (all ops):
  - `wb_reg_write = reg_write & (rd != 0) & ~misaligned`.
  - `wb_reg_write` is always 0 when `wb_valid=0`.
- **No accept** in a cycle: `wb_valid=0`, `misalign_err=0` next cycle. `wb_rd` and `wb_data` hold their last values.
- **Read-after-write:** a load accepted the cycle after a store to the same word returns the stored data.
- **WB side:** no back-pressure; WB always consumes `wb_*`.

## Timing
- **Latency:** ALU op, store and misaligned access: `wb_valid` one cycle after accept. Aligned load: two cycles after accept.
- **Throughput:** one op per cycle, except that a load occupies two cycles (`ex_ready` low during LOAD_WAIT).
- `ex_ready` is combinational from state only: 1 in IDLE, 0 in LOAD_WAIT. It does not depend on `ex_valid`.
- **Reset values:** state=IDLE, `ex_ready=1`, `wb_valid=0`, `wb_rd=0`, `wb_data=0`, `wb_reg_write=0`, `misalign_err=0`.
- **Reset during LOAD_WAIT:** the load is dropped, with no `wb_valid` pulse. The FSM returns to IDLE immediately (asynchronously).
- **Reset on a store-accept edge:** whether that memory write lands is unspecified. Benches must not depend on it.

## Test plan
- **ALU pass-through:** after reset, accept ALU op `ex_alu_result=25`, `ex_rd=5`, `ex_reg_write=1` → next cycle `wb_valid=1`, `wb_data=25`, `wb_rd=5`, `wb_reg_write=1`, `misalign_err=0`.
- **Store then load, back-to-back:**
  - Store `0xDEADBEEF` to address `0x10`, then load `0x10` into `rd=3`.
  - Store cycle: `wb_reg_write=0`.
  - `ex_ready=0` for exactly one cycle after the load accept.
  - `wb_data=0xDEADBEEF`, `wb_rd=3`, `wb_reg_write=1` two cycles after the load accept.
- **Misaligned store then load:**
  - Store `0x11111111` to `0x20`, then store `0x22222222` to `0x23` → second store gives `misalign_err=1` with `wb_valid`.
  - Load `0x20` → returns `0x11111111`.
  - A misaligned load of `0x21` → `wb_data=0`, `wb_reg_write=0`, no wait state.
- **`rd=0` and idle cycles:** ALU op with `ex_rd=0`, `ex_reg_write=1` → `wb_valid=1`, `wb_reg_write=0`. Then hold `ex_valid=0` for 3 cycles → `wb_valid=0`, with `wb_data` held.
- **Address wrap** (`MEM_WORDS=256`): store `0xCAFE0001` at `0x408` → load `0x008` returns `0xCAFE0001`.
- **Read/write both set, and reset mid-load:**
  - Op with read and write both set, data `0x5` at `0x30` → treated as a store; a later load of `0x30` returns `0x5`.
  - Assert `rst` while in LOAD_WAIT → no `wb_valid` pulse; `ex_ready=1` during reset and after release.
